hpm_counter_unit: RTL and testbench

Parametrised machine-mode hardware performance monitor for the RISC-X core. It implements mcycle, minstret, NUM_HPM programmable mhpmcounterN/mhpmeventN pairs, mcountinhibit and the read-only user shadows (cycle, instret, hpmcounterN). The unit sits beside the CSR file in the execute stage. It decodes its own address window and executes csr_operation_t read, write, set and clear operations.

---
 rtl/hpm_counter_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_hpm_counter_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_counter_unit.sv
// rtl/hpm_counter_unit.sv - machine-mode hardware performance monitor (mcycle, minstret, mhpm counters)
//
// Implements mcycle, minstret, NUM_HPM programmable mhpmcounterN/mhpmeventN
// pairs, mcountinhibit and the read-only user shadows. It decodes its own CSR
// window and executes read, write, set and clear operations.
//
// Parameters:
//   NUM_HPM     number of programmable counters (indices 3..3+NUM_HPM-1)
//   CNT_WIDTH   counter width, 33..64; bits above CNT_WIDTH-1 read as zero
//   NUM_EVENTS  width of events_i, 1..31
//
// Ports:
//   clk_i            core clock
//   rst_i            synchronous active-high reset
//   csr_access_i     a CSR instruction is executing this cycle
//   csr_op_i         csr_operation_t: read, write, set, clear
//   csr_addr_i       CSR address
//   csr_wdata_i      write/set/clear operand
//   csr_rdata_o      combinational read data (pre-write value), 0 on miss
//   csr_hit_o        address falls inside this unit's window
//   csr_illegal_o    write-type operation to a read-only user shadow
//   instr_retired_i  one instruction retires this cycle
//   events_i         event strobes, one count per cycle high
//   overflow_o       bit i pulses for one cycle after counter i wraps

module hpm_counter_unit #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_access_i,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [31:0]           csr_wdata_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    output logic                  csr_illegal_o,
    input  logic                  instr_retired_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    output logic [31:0]           overflow_o
);

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_operation_t;

    // Counter slots 0..NUM_CNT-1; slot 1 (time) exists only as a constant zero
    localparam int NUM_CNT     = 3 + NUM_HPM;
    localparam int HI_W        = CNT_WIDTH - 32;
    localparam int EV_W        = $clog2(NUM_EVENTS + 1);
    localparam int NUM_EV_REGS = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Writable mcountinhibit bits: mcycle, minstret and implemented HPM slots
    function automatic logic [31:0] calc_inh_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (i != 1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [31:0] INH_MASK = calc_inh_mask();

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [EV_W-1:0]      ev_q  [NUM_EV_REGS];
    logic [31:0]          inhibit_q;
    logic [31:0]          ovf_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    csr_operation_t op;
    logic [4:0]     idx;
    logic           sel_inhibit;
    logic           sel_event;
    logic           sel_counter;
    logic           sel_high;
    logic           sel_user;
    logic           write_type;
    logic           wr_en;
    logic           cnt_wr;

    assign op   = csr_operation_t'(csr_op_i);
    assign idx  = csr_addr_i[4:0];

    assign sel_inhibit = (csr_addr_i == 12'h320);
    // 0x320..0x33F, excluding 0x320..0x322 (inhibit handled above, 1 and 2 unused)
    assign sel_event   = (csr_addr_i[11:5] == 7'h19) && (idx >= 5'd3);
    // 0xB00/0xB80/0xC00/0xC80 blocks of 32; index 1 (time) is outside the window
    assign sel_counter = ((csr_addr_i[11:8] == 4'hB) || (csr_addr_i[11:8] == 4'hC)) &&
                         (csr_addr_i[6:5] == 2'b00) && (idx != 5'd1);
    assign sel_high    = csr_addr_i[7];
    assign sel_user    = (csr_addr_i[11:8] == 4'hC);

    assign csr_hit_o     = sel_inhibit || sel_event || sel_counter;
    assign write_type    = (op != CSR_READ);
    assign csr_illegal_o = csr_hit_o && write_type && sel_counter && sel_user;

    assign wr_en  = csr_access_i && csr_hit_o && write_type && !csr_illegal_o;
    assign cnt_wr = wr_en && sel_counter;

    // ------------------------------------------------------------------
    // Read mux: unimplemented indices fall through to zero
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (sel_inhibit) begin
            rdata = inhibit_q;
        end
        for (int n = 0; n < NUM_HPM; n++) begin
            if (sel_event && (idx == 5'(n + 3))) begin
                rdata = 32'(ev_q[n]);
            end
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (sel_counter && (idx == 5'(i))) begin
                rdata = sel_high ? 32'(cnt_q[i][CNT_WIDTH-1:32]) : cnt_q[i][31:0];
            end
        end
    end

    assign csr_rdata_o = rdata;

    // New value for write-type operations, formed from the pre-write read data
    logic [31:0] wr_val;

    always_comb begin
        wr_val = rdata;
        case (op)
            CSR_WRITE: wr_val = csr_wdata_i;
            CSR_SET:   wr_val = rdata | csr_wdata_i;
            CSR_CLEAR: wr_val = rdata & ~csr_wdata_i;
            default:   wr_val = rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-counter write strobes, increment enables and wrap detection
    // ------------------------------------------------------------------
    logic [NUM_CNT-1:0] wr_lo;
    logic [NUM_CNT-1:0] wr_hi;
    logic [NUM_CNT-1:0] inc_src;
    logic [NUM_CNT-1:0] inc;
    logic [31:0]        ovf_next;

    always_comb begin
        wr_lo = '0;
        wr_hi = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_wr && (idx == 5'(i))) begin
                wr_lo[i] = !sel_high;
                wr_hi[i] =  sel_high;
            end
        end
    end

    // Increment sources before inhibit; selector values outside
    // 1..NUM_EVENTS match no strobe and therefore count nothing
    always_comb begin
        inc_src    = '0;
        inc_src[0] = 1'b1;
        inc_src[2] = instr_retired_i;
        for (int n = 0; n < NUM_HPM; n++) begin
            for (int k = 1; k <= NUM_EVENTS; k++) begin
                if ((ev_q[n] == EV_W'(k)) && events_i[k-1]) begin
                    inc_src[n+3] = 1'b1;
                end
            end
        end
    end

    // The current inhibit value gates this cycle, so an mcountinhibit write
    // only affects counting from the following cycle
    assign inc = inc_src & ~inhibit_q[NUM_CNT-1:0];

    // A write to either half suppresses the increment and cannot wrap
    always_comb begin
        ovf_next = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            ovf_next[i] = inc[i] && !wr_lo[i] && !wr_hi[i] && (&cnt_q[i]);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inhibit_q <= '0;
            ovf_q     <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            for (int n = 0; n < NUM_EV_REGS; n++) begin
                ev_q[n] <= '0;
            end
        end else begin
            ovf_q <= ovf_next;

            if (wr_en && sel_inhibit) begin
                inhibit_q <= wr_val & INH_MASK;
            end

            for (int n = 0; n < NUM_HPM; n++) begin
                if (wr_en && sel_event && (idx == 5'(n + 3))) begin
                    ev_q[n] <= wr_val[EV_W-1:0];
                end
            end

            for (int i = 0; i < NUM_CNT; i++) begin
                if (wr_lo[i]) begin
                    cnt_q[i][31:0] <= wr_val;
                end else if (wr_hi[i]) begin
                    cnt_q[i][CNT_WIDTH-1:32] <= wr_val[HI_W-1:0];
                end else if (inc[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_hpm_counter_unit.sv
// tb/tb_hpm_counter_unit.sv - self-checking bench for hpm_counter_unit with a behavioural CSR model

module tb_hpm_counter_unit;

    localparam int NUM_HPM = 4;
    localparam int CNT_W   = 48;
    localparam int NE      = 8;
    localparam int EV_W    = $clog2(NE + 1);

    localparam logic [63:0] CMASK = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                  : ((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] EVM   = (32'd1 << EV_W) - 32'd1;

    localparam logic [1:0] OP_R = 2'd0;
    localparam logic [1:0] OP_W = 2'd1;
    localparam logic [1:0] OP_S = 2'd2;
    localparam logic [1:0] OP_C = 2'd3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          csr_access_i;
    logic [1:0]    csr_op_i;
    logic [11:0]   csr_addr_i;
    logic [31:0]   csr_wdata_i;
    logic [31:0]   csr_rdata_o;
    logic          csr_hit_o;
    logic          csr_illegal_o;
    logic          instr_retired_i;
    logic [NE-1:0] events_i;
    logic [31:0]   overflow_o;

    hpm_counter_unit #(
        .NUM_HPM    (NUM_HPM),
        .CNT_WIDTH  (CNT_W),
        .NUM_EVENTS (NE)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .csr_access_i    (csr_access_i),
        .csr_op_i        (csr_op_i),
        .csr_addr_i      (csr_addr_i),
        .csr_wdata_i     (csr_wdata_i),
        .csr_rdata_o     (csr_rdata_o),
        .csr_hit_o       (csr_hit_o),
        .csr_illegal_o   (csr_illegal_o),
        .instr_retired_i (instr_retired_i),
        .events_i        (events_i),
        .overflow_o      (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_errors = 0;
    int n_checks = 0;

    // Reference model state: counters by architectural index
    logic [63:0] m_cnt [32];
    logic [31:0] m_ev  [32];
    logic [31:0] m_inh;
    logic [31:0] m_ovf;

    logic [31:0] obs_rdata;
    logic        obs_hit;
    logic        obs_illegal;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit impl(input int n);
        return (n == 0) || (n == 2) || ((n >= 3) && (n < 3 + NUM_HPM));
    endfunction

    function automatic bit m_hit(input logic [11:0] a);
        return (a == 12'h320) || (a >= 12'h323 && a <= 12'h33F) ||
               (a == 12'hB00) || (a >= 12'hB02 && a <= 12'hB1F) ||
               (a == 12'hB80) || (a >= 12'hB82 && a <= 12'hB9F) ||
               (a == 12'hC00) || (a >= 12'hC02 && a <= 12'hC1F) ||
               (a == 12'hC80) || (a >= 12'hC82 && a <= 12'hC9F);
    endfunction

    function automatic bit m_user(input logic [11:0] a);
        return m_hit(a) && (a >= 12'hC00);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int n;
        logic [63:0] v;
        if (!m_hit(a)) return 32'h0;
        if (a == 12'h320) return m_inh;
        if (a < 12'h340) begin
            n = int'(a) - 'h320;
            return impl(n) ? m_ev[n] : 32'h0;
        end
        n = int'(a) % 32;
        v = impl(n) ? m_cnt[n] : 64'h0;
        return (a >= 12'hB80 && a < 12'hC00) || (a >= 12'hC80) ? v[63:32] : v[31:0];
    endfunction

    task automatic m_reset();
        for (int n = 0; n < 32; n++) begin
            m_cnt[n] = 64'h0;
            m_ev[n]  = 32'h0;
        end
        m_inh = 32'h0;
        m_ovf = 32'h0;
    endtask

    // One clock edge of the architectural behaviour
    task automatic m_clock(input bit r, input bit acc, input logic [1:0] op,
                           input logic [11:0] a, input logic [31:0] wd,
                           input bit ret, input logic [NE-1:0] ev);
        bit inc [32];
        bit wr  [32];
        int s;
        int n;
        logic [31:0] old_v;
        logic [31:0] nv;
        logic [31:0] inh_mask;
        m_ovf = 32'h0;
        if (r) begin
            m_reset();
            return;
        end
        inh_mask = 32'h0;
        for (int k = 0; k < 32; k++) begin
            if (impl(k)) inh_mask[k] = 1'b1;
        end
        for (int k = 0; k < 32; k++) begin
            inc[k] = 1'b0;
            wr[k]  = 1'b0;
            if (impl(k) && !m_inh[k]) begin
                if (k == 0) inc[k] = 1'b1;
                else if (k == 2) inc[k] = ret;
                else begin
                    s = int'(m_ev[k]);
                    if (s >= 1 && s <= NE) inc[k] = ev[s-1];
                end
            end
        end
        if (acc && m_hit(a) && op != OP_R && !m_user(a)) begin
            old_v = m_read(a);
            case (op)
                OP_W:    nv = wd;
                OP_S:    nv = old_v | wd;
                default: nv = old_v & ~wd;
            endcase
            if (a == 12'h320) begin
                m_inh = nv & inh_mask;
            end else if (a < 12'h340) begin
                n = int'(a) - 'h320;
                if (impl(n)) m_ev[n] = nv & EVM;
            end else begin
                n = int'(a) % 32;
                if (impl(n)) begin
                    wr[n] = 1'b1;
                    if (a >= 12'hB80) m_cnt[n] = {nv, m_cnt[n][31:0]} & CMASK;
                    else              m_cnt[n] = {m_cnt[n][63:32], nv};
                end
            end
        end
        for (int k = 0; k < 32; k++) begin
            if (inc[k] && !wr[k]) begin
                if (m_cnt[k] == CMASK) m_ovf[k] = 1'b1;
                m_cnt[k] = (m_cnt[k] + 64'd1) & CMASK;
            end
        end
    endtask

    // Drive one cycle, check combinational outputs, clock, check overflow
    task automatic step(input bit r, input bit acc, input logic [1:0] op,
                        input logic [11:0] a, input logic [31:0] wd,
                        input bit ret, input logic [NE-1:0] ev);
        rst_i           = r;
        csr_access_i    = acc;
        csr_op_i        = op;
        csr_addr_i      = a;
        csr_wdata_i     = wd;
        instr_retired_i = ret;
        events_i        = ev;
        #3;
        obs_rdata   = csr_rdata_o;
        obs_hit     = csr_hit_o;
        obs_illegal = csr_illegal_o;
        chk($sformatf("rdata@%h", a), csr_rdata_o, m_read(a));
        chk($sformatf("hit@%h", a), {31'b0, csr_hit_o}, {31'b0, m_hit(a)});
        chk($sformatf("illegal@%h", a), {31'b0, csr_illegal_o},
            {31'b0, m_hit(a) && op != OP_R && m_user(a)});
        @(posedge clk_i);
        m_clock(r, acc, op, a, wd, ret, ev);
        #1;
        chk("overflow", overflow_o, m_ovf);
    endtask

    task automatic rd(input logic [11:0] a, input bit ret);
        step(1'b0, 1'b0, OP_R, a, 32'h0, ret, '0);
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, op, a, d, 1'b0, '0);
    endtask

    logic [11:0]   r_addr;
    logic [31:0]   r_data;
    logic [NE-1:0] r_ev;
    logic [4:0]    r_idx;

    initial begin
        rst_i           = 1'b1;
        csr_access_i    = 1'b0;
        csr_op_i        = OP_R;
        csr_addr_i      = 12'h0;
        csr_wdata_i     = 32'h0;
        instr_retired_i = 1'b0;
        events_i        = '0;
        m_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        chk("reset_overflow", overflow_o, 32'h0);

        // Reset state, then 10 idle cycles
        step(1'b1, 1'b0, OP_R, 12'hB00, 32'h0, 1'b0, '0);
        chk("reset_mcycle", obs_rdata, 32'h0);
        for (int i = 0; i < 10; i++) rd(12'hB00, 1'b0);
        rd(12'hB00, 1'b0);
        chk("mcycle_after_10", obs_rdata, 32'd10);
        rd(12'hB02, 1'b0);
        chk("minstret_idle", obs_rdata, 32'd0);

        // mcycle wrap through both halves
        wr(OP_W, 12'hB00, 32'hFFFF_FFFF);
        wr(OP_W, 12'hB80, 32'hFFFF_FFFF);
        rd(12'hB80, 1'b0);
        chk("mcycle_hi_allones", obs_rdata, 32'h0000_FFFF);
        chk("wrap_pulse", overflow_o, 32'h1);
        rd(12'hB00, 1'b0);
        chk("mcycle_wrapped_lo", obs_rdata, 32'h0);
        chk("wrap_pulse_ends", overflow_o, 32'h0);
        rd(12'hB80, 1'b0);
        chk("mcycle_wrapped_hi", obs_rdata, 32'h0);

        // mcountinhibit freezes mcycle/minstret; clearing bit 0 resumes mcycle only
        wr(OP_W, 12'hB00, 32'h1234);
        wr(OP_W, 12'hB02, 32'h55);
        wr(OP_S, 12'h320, 32'h5);
        rd(12'hB00, 1'b1);
        chk("mcycle_frozen_a", obs_rdata, 32'h1236);
        rd(12'hB02, 1'b1);
        chk("minstret_frozen_a", obs_rdata, 32'h55);
        for (int i = 0; i < 3; i++) rd(12'hB00, 1'b1);
        rd(12'hB00, 1'b1);
        chk("mcycle_frozen_b", obs_rdata, 32'h1236);
        step(1'b0, 1'b1, OP_C, 12'h320, 32'h1, 1'b1, '0);
        chk("inhibit_before_clear", obs_rdata, 32'h5);
        rd(12'hB00, 1'b1);
        chk("mcycle_clear_cycle", obs_rdata, 32'h1236);
        rd(12'hB00, 1'b1);
        chk("mcycle_resumed", obs_rdata, 32'h1237);
        rd(12'hB02, 1'b1);
        chk("minstret_still_frozen", obs_rdata, 32'h55);
        rd(12'h320, 1'b0);
        chk("inhibit_after_clear", obs_rdata, 32'h4);

        // Event selection on mhpmcounter3
        wr(OP_W, 12'h323, 32'h2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, OP_R, 12'hB03, 32'h0, 1'b0, 8'h02);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, OP_R, 12'hB03, 32'h0, 1'b0, 8'h01);
        rd(12'hB03, 1'b0);
        chk("hpm3_count", obs_rdata, 32'd3);
        rd(12'hC03, 1'b0);
        chk("hpm3_shadow", obs_rdata, 32'd3);

        // Read-only shadow, unimplemented index, excluded time address
        wr(OP_W, 12'hB00, 32'h100);
        wr(OP_W, 12'hC00, 32'hDEAD);
        chk("shadow_write_illegal", {31'b0, obs_illegal}, 32'h1);
        rd(12'hB00, 1'b0);
        chk("mcycle_not_written", obs_rdata, 32'h101);
        step(1'b0, 1'b1, OP_R, 12'hC00, 32'h0, 1'b0, '0);
        chk("shadow_read_legal", {31'b0, obs_illegal}, 32'h0);
        wr(OP_W, 12'hB1F, 32'h1234_5678);
        rd(12'hB1F, 1'b0);
        chk("unimpl_hit", {31'b0, obs_hit}, 32'h1);
        chk("unimpl_zero", obs_rdata, 32'h0);
        rd(12'hB01, 1'b0);
        chk("time_miss", {31'b0, obs_hit}, 32'h0);
        chk("time_zero", obs_rdata, 32'h0);

        // Write beats increment; reset beats write, increment and wrap
        step(1'b0, 1'b1, OP_W, 12'hB03, 32'h100, 1'b0, 8'h02);
        rd(12'hB03, 1'b0);
        chk("write_beats_event", obs_rdata, 32'h100);
        wr(OP_W, 12'hB00, 32'hFFFF_FFFF);
        wr(OP_W, 12'hB80, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, OP_W, 12'hB02, 32'h77, 1'b1, 8'h02);
        chk("reset_no_overflow", overflow_o, 32'h0);
        rd(12'hB00, 1'b0);
        chk("reset_mcycle_mid", obs_rdata, 32'h0);
        rd(12'hB02, 1'b0);
        chk("reset_minstret_mid", obs_rdata, 32'h0);
        rd(12'hB03, 1'b0);
        chk("reset_hpm3_mid", obs_rdata, 32'h0);
        rd(12'h323, 1'b0);
        chk("reset_event3_mid", obs_rdata, 32'h0);
        rd(12'h320, 1'b0);
        chk("reset_inhibit_mid", obs_rdata, 32'h0);

        // Randomised traffic against the model
        for (int t = 0; t < 600; t++) begin
            r_idx = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 6))
                0:       r_addr = 12'h320;
                1:       r_addr = 12'h320 + {7'b0, r_idx};
                2:       r_addr = 12'hB00 + {7'b0, r_idx};
                3:       r_addr = 12'hB80 + {7'b0, r_idx};
                4:       r_addr = 12'hC00 + {7'b0, r_idx};
                5:       r_addr = 12'hC80 + {7'b0, r_idx};
                default: r_addr = 12'($urandom);
            endcase
            r_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            r_ev   = NE'($urandom);
            step($urandom_range(0, 99) == 0, 1'($urandom), 2'($urandom), r_addr,
                 r_data, 1'($urandom), r_ev);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
